// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and the
// baud-timing helpers used by both sides of the host-link bridge.
package uart_pkg;

  // One-hot receiver states
  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_DATA  = 4'b0100,
    S_STOP  = 4'b1000
  } uart_state_t;

  // Clock cycles per bit period (integer divide)
  function automatic int unsigned bit_cycles(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clock cycles in half a bit period, used to reach the start-bit centre
  function automatic int unsigned half_cycles(input int unsigned clk_freq,
                                              input int unsigned baud);
    return bit_cycles(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for the UART receiver: 2-FF synchroniser, delayed copy
// for falling-edge detection, and the sample value presented to the FSM.
// Build option: UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over the
// three most recent synchronised samples instead of a single sample.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic rx_in,
  output logic rx_bit,
  output logic rx_fall
);

  logic rx_meta;
  logic rx_s;
  logic rx_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rx_d2;
`endif

  // Synchronise the line and keep delayed copies; idle-high reset value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_d2   <= 1'b1;
`endif
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
`ifdef UART_RX_MAJORITY_VOTE_EN
      rx_d2   <= rx_d;
`endif
    end
  end

  assign rx_fall = rx_d & ~rx_s;

`ifdef UART_RX_MAJORITY_VOTE_EN
  assign rx_bit = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
  assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, idle-high line. Received bytes are
// presented on an AXI-Stream-style master port, one byte per packet.
// Build option: UART_RX_MAJORITY_VOTE_EN (2-of-3 vote at each sample point,
// handled inside uart_rx_sync; timing is unchanged).
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_uart_rx,
  input  logic       i_tready,
  output logic       o_tvalid,
  output logic [7:0] o_tdata,
  output logic       o_tkeep,
  output logic       o_tlast,
  output logic       o_frame_err,
  output logic       o_overflow
);

  localparam int unsigned BIT_CYC   = bit_cycles(CLK_FREQ, BAUD);
  localparam int unsigned HALF_CYC  = half_cycles(CLK_FREQ, BAUD);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);

  logic        rx_bit;
  logic        rx_fall;
  uart_state_t state;
  logic [15:0] cyc_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;

  uart_rx_sync u_sync (
    .clk     (clk),
    .rstn    (rstn),
    .rx_in   (i_uart_rx),
    .rx_bit  (rx_bit),
    .rx_fall (rx_fall)
  );

  assign o_tkeep = 1'b1;
  assign o_tlast = 1'b1;

  // Receive FSM with registered stream outputs and error pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      o_tvalid    <= 1'b0;
      o_tdata     <= '0;
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_frame_err <= 1'b0;
      o_overflow  <= 1'b0;
      if (o_tvalid && i_tready) begin
        o_tvalid <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (rx_fall) begin
            state <= S_START;
          end
        end
        S_START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            state   <= rx_bit ? S_IDLE : S_DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt        <= '0;
            shift[bit_cnt] <= rx_bit;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (cyc_cnt == BIT_LAST) begin
            cyc_cnt <= '0;
            state   <= S_IDLE;
            if (rx_bit) begin
              // Slot is free if empty or being drained this cycle
              if (!o_tvalid || i_tready) begin
                o_tvalid <= 1'b1;
                o_tdata  <= shift;
              end else begin
                o_overflow <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: begin
          state   <= S_IDLE;
          cyc_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are generated at the line
// level, expected bytes go into a scoreboard queue, and a negedge monitor
// pops and compares on every accepted beat.
module tb_uart_rx;

  localparam int BIT_CYC = 50000000 / 115200;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       line = 1'b1;
  logic       tready = 1'b0;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tkeep;
  logic       tlast;
  logic       frame_err;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int ferr_seen = 0;
  int ovf_seen = 0;
  int exp_ferr = 0;
  int exp_ovf = 0;
  bit rand_ready = 1'b0;
  bit hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  bit glitch_en = 1'b0;

  always #10 clk = ~clk;

  uart_rx dut (
    .clk         (clk),
    .rstn        (rstn),
    .i_uart_rx   (line),
    .i_tready    (tready),
    .o_tvalid    (tvalid),
    .o_tdata     (tdata),
    .o_tkeep     (tkeep),
    .o_tlast     (tlast),
    .o_frame_err (frame_err),
    .o_overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: count pulses, check handshake stability, score accepted beats
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) ferr_seen++;
      if (overflow) ovf_seen++;
      if (hold_prev) begin
        check("tvalid_held", {31'd0, tvalid}, 32'd1);
        check("tdata_stable", {24'd0, tdata}, {24'd0, data_prev});
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %02h expected none", tdata);
        end else begin
          logic [7:0] exp_b;
          exp_b = exp_q.pop_front();
          $display("beat data=%02h expected=%02h", tdata, exp_b);
          check("tdata", {24'd0, tdata}, {24'd0, exp_b});
          check("tkeep", {31'd0, tkeep}, 32'd1);
          check("tlast", {31'd0, tlast}, 32'd1);
        end
      end
      hold_prev = tvalid && !tready;
      data_prev = tdata;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    for (int i = 0; i < BIT_CYC; i++) begin
      if (glitch && i == BIT_CYC / 2) line = ~v;
      else line = v;
      tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit glitch);
    $display("tx byte=%02h stop=%0b glitch=%0b", b, stop, glitch);
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 8; k++) drive_bit(b[k], glitch);
    drive_bit(stop, 1'b0);
    line = 1'b1;
  endtask

  task automatic idle(input int n);
    line = 1'b1;
    repeat (n) tick();
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic check_pulses(input string name);
    check({name, "_frame_err"}, ferr_seen, exp_ferr);
    check({name, "_overflow"}, ovf_seen, exp_ovf);
  endtask

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
`ifdef UART_RX_MAJORITY_VOTE_EN
    glitch_en = 1'b1;
`endif
    // Reset values
    rstn = 1'b0;
    line = 1'b1;
    tready = 1'b0;
    repeat (5) tick();
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", {24'd0, tdata}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rstn = 1'b1;
    idle(20);

    // Basic frame
    tready = 1'b1;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    wait_drain(2000, "a5_drain");
    check_pulses("a5");

    // False start, then a good frame
    line = 1'b0;
    repeat (100) tick();
    idle(600);
    check("false_start_tvalid", {31'd0, tvalid}, 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    wait_drain(2000, "3c_drain");
    check_pulses("false_start");

    // Framing error, then recovery
    exp_ferr++;
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(BIT_CYC);
    check("ferr_tvalid", {31'd0, tvalid}, 32'd0);
    check_pulses("ferr");
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(20);
    wait_drain(2000, "5a_drain");
    check_pulses("after_ferr");

    // Overflow: output held while a second byte arrives
    tready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    exp_ovf++;
    idle(20);
    check("ovf_tvalid", {31'd0, tvalid}, 32'd1);
    check("ovf_tdata", {24'd0, tdata}, 32'h11);
    check_pulses("ovf");
    tready = 1'b1;
    wait_drain(50, "ovf_drain");
    idle(20);
    check("ovf_after_tvalid", {31'd0, tvalid}, 32'd0);

    // Back-to-back with ready held high
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h80);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b0);
    idle(20);
    wait_drain(2000, "b2b_drain");
    check_pulses("b2b");

    // Reset during bit 4 of 0xC3; the transmitter side aborts too
    rb = 8'hC3;
    drive_bit(1'b0, 1'b0);
    for (int k = 0; k < 4; k++) drive_bit(rb[k], 1'b0);
    line = rb[4];
    repeat (200) tick();
    rstn = 1'b0;
    line = 1'b1;
    repeat (3) tick();
    check("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    rstn = 1'b1;
    idle(2 * BIT_CYC);
    check("midrst_no_beat", {31'd0, tvalid}, 32'd0);
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1, glitch_en);
    idle(20);
    wait_drain(2000, "96_drain");
    check_pulses("midrst");

    // Randomised frames with random ready
    rand_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      if (rs) exp_q.push_back(rb);
      else exp_ferr++;
      send_frame(rb, rs, 1'b0);
      idle(rs ? int'($urandom_range(1, 40)) : BIT_CYC);
    end
    rand_ready = 1'b0;
    tready = 1'b1;
    idle(20);
    wait_drain(2000, "rand_drain");
    check_pulses("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
